// File: rtl/pipe_stage_buffer_pkg.sv
// Basic types shared by the pipeline stage buffer: the execute-stage bundle,
// the depth limit and a pointer-width helper.
package pipe_stage_buffer_pkg;

  localparam int PIPE_BUF_MAX_DEPTH = 8;

  // Decode -> execute bundle; its $bits sets the buffer WIDTH.
  typedef struct packed {
    logic [31:0] pc;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [16:0] imm;
  } ExecuteStagePipeReg;

  // A pointer into a DEPTH-entry array; a single-entry array still needs one bit.
  function automatic int ptrWidth(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

endpackage

// File: rtl/pipe_buffer_ptr.sv
// Wrap-around index 0..DEPTH-1 with increment enable and synchronous clear.
// The wrap is an explicit compare so non-power-of-two depths work.
module pipe_buffer_ptr
  import pipe_stage_buffer_pkg::*;
#(
  parameter  int DEPTH = 2,
  localparam int PW    = ptrWidth(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clear,
  input  logic          inc,
  output logic [PW-1:0] ptr
);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr <= '0;
    end else if (clear) begin
      ptr <= '0;
    end else if (inc) begin
      ptr <= (ptr == PW'(DEPTH - 1)) ? '0 : ptr + PW'(1);
    end
  end

endmodule

// File: rtl/pipe_stage_buffer.sv
// Elastic DEPTH-entry FIFO between two CPU pipeline stages, with flush and
// occupancy. Define PIPE_STAGE_BUFFER_PERF_EN to build the upstream-stall counter.
module pipe_stage_buffer
  import pipe_stage_buffer_pkg::*;
#(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 2,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CW-1:0]    occupancy,
  output logic [31:0]      stall_cycles
);

  localparam int PW = ptrWidth(DEPTH);

  if (DEPTH < 1 || DEPTH > PIPE_BUF_MAX_DEPTH) begin : gBadDepth
    $error("pipe_stage_buffer: DEPTH out of range");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    rdPtr;
  logic [PW-1:0]    wrPtr;
  logic [CW-1:0]    countReg;
  logic             push;
  logic             pop;

  // in_ready depends only on registered count and reset, never on out_ready.
  assign in_ready  = (countReg != CW'(DEPTH)) & rst;
  assign out_valid = (countReg != '0);
  assign out_data  = mem[rdPtr];
  assign occupancy = countReg;

  assign push = in_valid & in_ready & ~flush;
  assign pop  = out_valid & out_ready & ~flush;

  pipe_buffer_ptr #(.DEPTH(DEPTH)) uRdPtr (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .inc   (pop),
    .ptr   (rdPtr)
  );

  pipe_buffer_ptr #(.DEPTH(DEPTH)) uWrPtr (
    .clk   (clk),
    .rst   (rst),
    .clear (flush),
    .inc   (push),
    .ptr   (wrPtr)
  );

  // Entries are not reset or cleared; count alone decides what is live.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : gEntry
    always_ff @(posedge clk) begin
      if (push && (wrPtr == PW'(gi))) begin
        mem[gi] <= in_data;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      countReg <= '0;
    end else if (flush) begin
      countReg <= '0;
    end else if (push && !pop) begin
      countReg <= countReg + CW'(1);
    end else if (pop && !push) begin
      countReg <= countReg - CW'(1);
    end
  end

`ifdef PIPE_STAGE_BUFFER_PERF_EN
  logic [31:0] stallCntReg;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stallCntReg <= '0;
    end else if (in_valid && !in_ready && !flush && (stallCntReg != 32'hFFFF_FFFF)) begin
      stallCntReg <= stallCntReg + 32'd1;
    end
  end

  assign stall_cycles = stallCntReg;
`else
  assign stall_cycles = '0;
`endif

  // Upstream must hold its bundle while it is being back-pressured.
  inDataStable: assert property (
    @(posedge clk) disable iff (!rst)
    (in_valid && !in_ready && !flush) |=> (!in_valid || $stable(in_data))
  );

endmodule

// File: tb/tb_pipe_stage_buffer.sv
// Directed bench for pipe_stage_buffer: DEPTH=2 and DEPTH=3 instances, with a
// queue scoreboard checked by negedge monitors.
module tb_pipe_stage_buffer;
  import pipe_stage_buffer_pkg::*;

  localparam int W = $bits(ExecuteStagePipeReg);
`ifdef PIPE_STAGE_BUFFER_PERF_EN
  localparam logic [31:0] STALL_EXP  = 32'd5;
  localparam logic [31:0] STALL_EXP2 = 32'd6;
`else
  localparam logic [31:0] STALL_EXP  = 32'd0;
  localparam logic [31:0] STALL_EXP2 = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic         aFlush = 0, aInValid = 0, aOutReady = 0;
  logic [W-1:0] aData = '0;
  logic         aInReady, aOutValid;
  logic [W-1:0] aOutData;
  logic [1:0]   aOcc;
  logic [31:0]  aStall;

  logic         bFlush = 0, bInValid = 0, bOutReady = 0;
  logic [W-1:0] bData = '0;
  logic         bInReady, bOutValid;
  logic [W-1:0] bOutData;
  logic [1:0]   bOcc;
  logic [31:0]  bStall;

  pipe_stage_buffer #(.WIDTH(W), .DEPTH(2)) dutA (
    .clk(clk), .rst(rst), .flush(aFlush),
    .in_valid(aInValid), .in_ready(aInReady), .in_data(aData),
    .out_valid(aOutValid), .out_ready(aOutReady), .out_data(aOutData),
    .occupancy(aOcc), .stall_cycles(aStall)
  );

  pipe_stage_buffer #(.WIDTH(W), .DEPTH(3)) dutB (
    .clk(clk), .rst(rst), .flush(bFlush),
    .in_valid(bInValid), .in_ready(bInReady), .in_data(bData),
    .out_valid(bOutValid), .out_ready(bOutReady), .out_data(bOutData),
    .occupancy(bOcc), .stall_cycles(bStall)
  );

  int tests = 0;
  int failures = 0;
  logic [W-1:0] qA[$];
  logic [W-1:0] qB[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = 0x%0h", name, act);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitors: a handshake at this negedge completes on the next rising edge.
  always @(negedge clk) begin
    if (rst && aOutValid && aOutReady && !aFlush) begin
      if (qA.size() == 0) begin
        tests++; failures++;
        $display("FAIL A_unexpected: got 0x%0h, expected no output", aOutData);
      end else begin
        check("A_out", aOutData, qA.pop_front());
      end
    end
  end

  always @(negedge clk) begin
    if (rst && bOutValid && bOutReady && !bFlush) begin
      if (qB.size() == 0) begin
        tests++; failures++;
        $display("FAIL B_unexpected: got 0x%0h, expected no output", bOutData);
      end else begin
        check("B_out", bOutData, qB.pop_front());
      end
    end
  end

  initial begin
    #50000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    #2;
    check("rst_A_valid", aOutValid, 0);
    check("rst_A_ready", aInReady, 0);
    check("rst_A_occ",   aOcc, 0);
    check("rst_A_stall", aStall, 0);
    check("rst_B_valid", bOutValid, 0);
    check("rst_B_ready", bInReady, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    #1;
    check("rel_A_ready", aInReady, 1);
    check("rel_B_ready", bInReady, 1);
    step();

    // Fill DEPTH=2 with out_ready low, then drain
    aInValid = 1; aData = 'hA1; aOutReady = 1; qA.push_back('hA1);
    #0 check("nobypass_valid", aOutValid, 0);
    aOutReady = 0;
    step();
    check("lat_valid", aOutValid, 1);
    aData = 'hB2; qA.push_back('hB2);
    step();
    aInValid = 0;
    check("full_occ",   aOcc, 2);
    check("full_ready", aInReady, 0);
    check("full_head",  aOutData, 'hA1);
    aOutReady = 1;
    step();
    step();
    aOutReady = 0;
    check("drain_valid", aOutValid, 0);
    check("drain_occ",   aOcc, 0);

    // DEPTH=3 streaming 0..9, both pointers wrap
    bOutReady = 1;
    for (int i = 0; i < 10; i++) begin
      bInValid = 1; bData = W'(i); qB.push_back(W'(i));
      step();
      check($sformatf("stream_occ_%0d", i), bOcc, 1);
    end
    bInValid = 0;
    step();
    bOutReady = 0;
    check("stream_end_valid", bOutValid, 0);
    check("stream_drained", qB.size(), 0);

    // Flush with a same-cycle push
    aInValid = 1; aData = 'h11; qA.push_back('h11);
    step();
    aData = 'h22; qA.push_back('h22);
    step();
    aData = 'hCC; aFlush = 1; qA.delete();
    check("preflush_ready", aInReady, 0);
    step();
    aFlush = 0; aInValid = 0;
    check("flush_occ",   aOcc, 0);
    check("flush_valid", aOutValid, 0);
    check("flush_ready", aInReady, 1);
    aOutReady = 1;
    step();
    step();
    aOutReady = 0;
    check("flush_no_cc", aOutValid, 0);

    // Stall counter: full with in_valid held for five cycles
    aInValid = 1; aData = 'h61; qA.push_back('h61);
    step();
    aData = 'h72; qA.push_back('h72);
    step();
    aData = 'h83;
    repeat (5) step();
    aInValid = 0;
    check("stall_count", aStall, STALL_EXP);
    aOutReady = 1;
    step();
    step();
    aOutReady = 0;
    check("stall_drain_occ", aOcc, 0);

    // Full + pop + valid input: pop only, input accepted next cycle
    aInValid = 1; aData = 'h31; qA.push_back('h31);
    step();
    aData = 'h42; qA.push_back('h42);
    step();
    aData = 'h53; aOutReady = 1; qA.push_back('h53);
    #0 check("fullpop_ready", aInReady, 0);
    step();
    check("fullpop_occ",   aOcc, 1);
    check("fullpop_ready2", aInReady, 1);
    step();
    aInValid = 0;
    check("fullpop_occ2", aOcc, 1);
    step();
    aOutReady = 0;
    check("fullpop_end_occ", aOcc, 0);
    check("stall_count2", aStall, STALL_EXP2);

    // Asynchronous reset mid-cycle with one entry held
    aInValid = 1; aData = 'h94;
    step();
    aInValid = 0;
    check("prerst_valid", aOutValid, 1);
    #2 rst = 1'b0;
    #1;
    qA.delete();
    check("arst_valid", aOutValid, 0);
    check("arst_ready", aInReady, 0);
    check("arst_occ",   aOcc, 0);
    check("arst_stall", aStall, 0);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("arel_ready", aInReady, 1);
    check("arel_valid", aOutValid, 0);
    step();

    check("A_drained", qA.size(), 0);
    check("B_stall",   bStall, 0);
    $display("[TB] %0d tests run, %0d failed", tests, failures);
    $finish;
  end

endmodule
